// File: rtl/fib_index_finder.sv
// fib_index_finder
//   Decodes a value back to its Fibonacci index: walks F(0), F(1), ... one
//   term per cycle and returns the smallest k with F(k) >= value, plus a flag
//   that is set when F(k) equals the value exactly. One request in flight.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request, in_ready = 1
//   SEARCH | stepping a/b/k until a >= val
//   DONE   | result held on out_index/out_exact, out_valid = 1
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request value presented
//   in_ready   block can accept a request (IDLE)
//   in_value   W-bit value to decode
//   out_valid  result held (DONE)
//   out_ready  consumer takes the result
//   out_index  smallest k with F(k) >= value (registered)
//   out_exact  F(out_index) == value (registered)
module fib_index_finder #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_exact
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   val;
    // Two extra bits so the term just past the largest W-bit value (and the
    // sum that precedes it) are held without wrapping.
    logic [W+1:0]   a;
    logic [W+1:0]   b;
    logic [IDX_W-1:0] k;
    logic [W+1:0]   val_ext;

    assign val_ext   = {2'b00, val};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            val       <= '0;
            a         <= '0;
            b         <= '0;
            k         <= '0;
            out_index <= '0;
            out_exact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        val   <= in_value;
                        a     <= '0;
                        b     <= {{(W+1){1'b0}}, 1'b1};
                        k     <= '0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (a >= val_ext) begin
                        out_index <= k;
                        out_exact <= (a == val_ext);
                        state     <= DONE;
                    end else begin
                        a <= b;
                        b <= a + b;
                        k <= k + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fib_index_finder.md
# fib_index_finder

Inverse companion to the Fibonacci generator chip: accepts a W-bit value over a valid/ready handshake, iteratively walks the Fibonacci sequence, and returns the index of the first term at or above that value, plus an exact-match flag. Where the generator maps an index N to F(N), this block maps a value back to N. It sits on the consumer side of a Fibonacci value stream and can check or decode generator output. It is one unit with one request in flight at a time.

## Interface
Parameters:
- `W`, default 8: input value width.
- `IDX_W`, default 4: index width. Must hold the smallest k with F(k) ≥ 2^W − 1. For W = 8 this is k = 14.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_value` is presented.
- `in_ready`, out, 1: the block can accept a request.
- `in_value`, in, W: value to decode.
- `out_valid`, out, 1: a result is held.
- `out_ready`, in, 1: the consumer takes the result.
- `out_index`, out, IDX_W: smallest k with F(k) ≥ value.
- `out_exact`, out, 1: 1 when F(out_index) equals the value.

## Operation
- Sequence convention: F(0)=0, F(1)=1, F(k)=F(k−1)+F(k−2). This gives 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377.
- Value 1 resolves to index 1, the smallest index.
- Internal registers:
  - `val` (W bits): latched request value.
  - `a`, `b` (W+2 bits each): current and next Fibonacci terms. W+2 bits guarantees `a+b` never wraps before the search ends.
  - `k` (IDX_W bits): step counter.
- FSM states are IDLE, SEARCH and DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: `val`←`in_value`, `a`←0, `b`←1, `k`←0, go to SEARCH.
- SEARCH:
  - `in_ready`=0.
  - If `a` ≥ zero-extended `val`: `out_index`←`k`, `out_exact`←(`a`==`val`), go to DONE.
  - Otherwise: `a`←`b`, `b`←`a+b`, `k`←`k+1`, stay in SEARCH.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - On `out_ready`: go to IDLE.
  - `in_valid` is ignored until the return to IDLE.
- Values above the largest representable term (W=8: 234..255) return index 14 with exact=0. This works because F(14)=377 is held in the widened registers.
- `out_index` and `out_exact` are registered. They stay stable throughout DONE and keep their last value after the handshake until the next result is loaded.
- `in_ready` and `out_valid` are decoded directly from the state register.

## Timing
- Reset state: IDLE.
- Values while `rst_n`=0: `in_ready`=1, `out_valid`=0, `out_index`=0, `out_exact`=0. `a`, `b`, `k` and `val` are cleared.
- Reset asserted mid-SEARCH or in DONE:
  - The request is aborted immediately (asynchronously).
  - No result is produced.
  - After `rst_n` deasserts, the block accepts a new request on the first rising edge.
- Accept edge T: the rising edge where `in_valid` and `in_ready` are both 1.
- During the cycle after edge T+j, `a`=F(j).
- For result index k, `out_valid` rises after edge T+k+1, so latency is k+1 cycles:
  - value 0: 1 cycle
  - value 13: 8 cycles
  - value 233: 14 cycles
  - value 255: 15 cycles
- Result handshake: the result transfers on the rising edge where `out_valid && out_ready`. `out_valid` falls after that edge.
- Throughput:
  - The earliest next accept is the edge after the result handshake.
  - Minimum request spacing is k+3 cycles: accept, k+1 search cycles, output handshake.
- `out_ready` held high while in DONE: the block still spends exactly one cycle in DONE.
- No combinational path from inputs to outputs.

## Test plan
- Reset:
  - Assert `rst_n`=0 for 3 cycles with `in_valid`=1 → `in_ready`=1, `out_valid`=0, `out_index`=0, `out_exact`=0 throughout.
  - After release, the first edge accepts.
- Exact hits, each with `out_ready`=1:
  - 0 → index 0, exact 1, after 1 cycle.
  - 1 → index 1, exact 1, after 2 cycles.
  - 13 → index 7, exact 1, after 8 cycles.
  - 233 → index 13, exact 1, after 14 cycles.
- Non-members:
  - 4 → index 5, exact 0.
  - 100 → index 12, exact 0.
  - 255 → index 14, exact 0, after 15 cycles.
- Backpressure and overlap:
  - Send 21 with `out_ready`=0 for 6 cycles after `out_valid` rises → index 8 and exact 1 held stable.
  - `in_ready`=0 throughout, and a new `in_valid` pulse of 50 during DONE is ignored.
  - Release `out_ready` → IDLE on the next edge, then 50 is accepted and returns index 10, exact 0.
- Reset mid-operation:
  - Send 200, then pull `rst_n` low 5 cycles after accept → `out_valid` never asserts and `in_ready`=1 immediately.
  - After release, send 8 → index 6, exact 1, after 7 cycles.
- Back-to-back stream:
  - Send 0,1,1,2,3,5,8,13,21,34,55,89,144,233 with `in_valid` held high and `out_ready`=1.
  - Expect indices 0,1,1,3,4,…,13 (the repeated 1 again returns index 1), all exact 1.
  - Check spacing of index+3 cycles between accepts.
